// File: rtl/note_player.sv
// note_player
//   Plays note codes handed over by the music sequencer as a square wave on the
//   buzzer. Each note is buffered in a small FIFO, loaded, played for a fixed
//   beat and followed by a silent gap. Once the sequencer's end marker has been
//   seen and every buffered note has finished, done pulses for one cycle.
//
//   Handshake: note_vld / seq_end are one-cycle strobes with no acknowledge.
//   note_rdy is advisory only; a note strobed while the buffer is full and no
//   slot is being freed in the same cycle is dropped and overflow latches high.
//
// Parameters
//   PRESCALE    clocks per note_code LSB (power of 2)
//   BEAT_CYC    PLAY length per note in cycles (>= 2)
//   GAP_CYC     silent gap after each note in cycles (>= 1)
//   FIFO_DEPTH  note buffer entries (power of 2, >= 2)
//
// Ports
//   sysclk     in   system clock, rising edge
//   rst        in   synchronous reset, active-high
//   note_code  in   half-period code, 0 = rest
//   note_vld   in   note_code valid strobe
//   seq_end    in   sequence finished strobe
//   mute       in   forces buzz low without affecting timing
//   note_rdy   out  buffer not full
//   buzz       out  square-wave buzzer drive
//   playing    out  high in LOAD, PLAY and GAP
//   done       out  one-cycle pulse after the last note following seq_end
//   overflow   out  sticky: a note was dropped because the buffer was full
module note_player #(
    parameter int PRESCALE   = 64,
    parameter int BEAT_CYC   = 12500000,
    parameter int GAP_CYC    = 500000,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       sysclk,
    input  logic       rst,
    input  logic [9:0] note_code,
    input  logic       note_vld,
    input  logic       seq_end,
    input  logic       mute,
    output logic       note_rdy,
    output logic       buzz,
    output logic       playing,
    output logic       done,
    output logic       overflow
);

    localparam int PS_W   = $clog2(PRESCALE);
    localparam int HP_W   = 10 + PS_W;
    localparam int BEAT_W = $clog2(BEAT_CYC);
    localparam int GAP_W  = $clog2(GAP_CYC + 1);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        PLAY = 3'd2,
        GAP  = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t state;
    state_t state_nxt;

    // ------------------------------------------------------------------
    // Note FIFO. Pointers carry one extra wrap bit to tell full from empty.
    // ------------------------------------------------------------------
    logic [9:0]     mem [FIFO_DEPTH];
    logic [PTR_W:0] wr_ptr;
    logic [PTR_W:0] rd_ptr;
    logic           empty;
    logic           full;
    logic           pop;
    logic           push;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

    // A pop in the same cycle frees a slot, so a full buffer still accepts.
    assign push = note_vld && (!full || pop);

    always_ff @(posedge sysclk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge sysclk) begin
        if (push) mem[wr_ptr[PTR_W-1:0]] <= note_code;
    end

    // ------------------------------------------------------------------
    // Sticky overflow and pending end marker
    // ------------------------------------------------------------------
    logic end_pend;

    always_ff @(posedge sysclk) begin
        if (rst) begin
            overflow <= 1'b0;
            end_pend <= 1'b0;
        end else begin
            if (note_vld && full && !pop) overflow <= 1'b1;
            // A fresh end marker arriving while DONE is shown is kept.
            if (seq_end)            end_pend <= 1'b1;
            else if (state == DONE) end_pend <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Counters and tone generator
    // ------------------------------------------------------------------
    logic [9:0]        cur_code;
    logic [HP_W-1:0]   hp;
    logic [HP_W-1:0]   half_cnt;
    logic [BEAT_W-1:0] beat_cnt;
    logic [GAP_W-1:0]  gap_cnt;
    logic              buzz_q;
    logic              beat_last;
    logic              gap_last;

    assign beat_last = (beat_cnt == BEAT_W'(BEAT_CYC - 1));
    assign gap_last  = (gap_cnt  == GAP_W'(GAP_CYC - 1));

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge sysclk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (!empty)        state_nxt = LOAD;
                else if (end_pend) state_nxt = DONE;
            end
            LOAD: state_nxt = PLAY;
            PLAY: begin
                if (beat_last) state_nxt = GAP;
            end
            GAP: begin
                if (gap_last) begin
                    if (!empty)        state_nxt = LOAD;
                    else if (end_pend) state_nxt = DONE;
                    else               state_nxt = IDLE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        pop     = 1'b0;
        playing = 1'b0;
        done    = 1'b0;
        case (state)
            IDLE: pop = !empty;
            LOAD: playing = 1'b1;
            PLAY: playing = 1'b1;
            GAP: begin
                playing = 1'b1;
                pop     = gap_last && !empty;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge sysclk) begin
        if (rst) begin
            cur_code <= '0;
            hp       <= '0;
            half_cnt <= '0;
            beat_cnt <= '0;
            gap_cnt  <= '0;
            buzz_q   <= 1'b0;
        end else begin
            // The popped entry is captured here so LOAD sees a stable code.
            if (pop) cur_code <= mem[rd_ptr[PTR_W-1:0]];

            case (state)
                LOAD: begin
                    hp       <= HP_W'(cur_code) << PS_W;
                    half_cnt <= '0;
                    beat_cnt <= '0;
                    gap_cnt  <= '0;
                    buzz_q   <= 1'b0;
                end
                PLAY: begin
                    beat_cnt <= beat_cnt + BEAT_W'(1);
                    gap_cnt  <= '0;
                    // hp == 0 is a rest: the tone generator stays idle.
                    if (hp != '0) begin
                        if (half_cnt == hp - HP_W'(1)) begin
                            half_cnt <= '0;
                            buzz_q   <= ~buzz_q;
                        end else begin
                            half_cnt <= half_cnt + HP_W'(1);
                        end
                    end
                    // Last beat cycle overrides any toggle so the gap is silent.
                    if (beat_last) buzz_q <= 1'b0;
                end
                GAP: begin
                    gap_cnt <= gap_cnt + GAP_W'(1);
                    buzz_q  <= 1'b0;
                end
                default: buzz_q <= 1'b0;
            endcase
        end
    end

    assign buzz     = buzz_q & ~mute;
    assign note_rdy = !full;

endmodule

// File: tb/tb_note_player.sv
// tb_note_player
//   Directed bench for note_player with PRESCALE=2, BEAT_CYC=40, GAP_CYC=4,
//   FIFO_DEPTH=2. A 5-unit note gives hp=10: a note strobed in cycle N loads
//   in N+2, plays N+3..N+42, gaps N+43..N+46, so playing spans 45 cycles.
//   Outputs are logged per cycle on the falling edge and checked afterwards.
module tb_note_player;

    localparam int PRESCALE   = 2;
    localparam int BEAT_CYC   = 40;
    localparam int GAP_CYC    = 4;
    localparam int FIFO_DEPTH = 2;
    localparam int LOG_N      = 4096;

    // ------------------------------------------------------------------
    // Clock / reset / DUT
    // ------------------------------------------------------------------
    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] note_code;
    logic       note_vld;
    logic       seq_end;
    logic       mute;
    logic       note_rdy;
    logic       buzz;
    logic       playing;
    logic       done;
    logic       overflow;

    always #5 clk = ~clk;

    note_player #(
        .PRESCALE  (PRESCALE),
        .BEAT_CYC  (BEAT_CYC),
        .GAP_CYC   (GAP_CYC),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .sysclk   (clk),
        .rst      (rst),
        .note_code(note_code),
        .note_vld (note_vld),
        .seq_end  (seq_end),
        .mute     (mute),
        .note_rdy (note_rdy),
        .buzz     (buzz),
        .playing  (playing),
        .done     (done),
        .overflow (overflow)
    );

    // Cycle number: count of rising edges so far.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic bz_log  [LOG_N];
    logic pl_log  [LOG_N];
    logic dn_log  [LOG_N];
    logic rdy_log [LOG_N];
    logic ov_log  [LOG_N];

    always @(negedge clk) begin
        if (cyc < LOG_N) begin
            bz_log[cyc]  = buzz;
            pl_log[cyc]  = playing;
            dn_log[cyc]  = done;
            rdy_log[cyc] = note_rdy;
            ov_log[cyc]  = overflow;
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    int   tests_run    = 0;
    int   tests_failed = 0;
    logic exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // sel: 0 buzz, 1 playing, 2 done
    function automatic int count_high(input int sel, input int a, input int b);
        int n = 0;
        for (int i = a; i <= b; i++) begin
            case (sel)
                0:       if (bz_log[i] === 1'b1) n++;
                1:       if (pl_log[i] === 1'b1) n++;
                default: if (dn_log[i] === 1'b1) n++;
            endcase
        end
        return n;
    endfunction

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) tick();
    endtask

    task automatic strobe_note(input logic [9:0] code, output int n);
        note_code = code;
        note_vld  = 1'b1;
        n         = cyc;
        tick();
        note_vld  = 1'b0;
    endtask

    task automatic pulse_end(output int m);
        seq_end = 1'b1;
        m       = cyc;
        tick();
        seq_end = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int n;
        int m;
        int d;
        int trans;

        rst       = 1'b1;
        note_code = '0;
        note_vld  = 1'b0;
        seq_end   = 1'b0;
        mute      = 1'b0;
        repeat (3) tick();

        check("rst_buzz",     buzz,     0);
        check("rst_playing",  playing,  0);
        check("rst_done",     done,     0);
        check("rst_overflow", overflow, 0);
        check("rst_note_rdy", note_rdy, 1);
        rst = 1'b0;
        repeat (2) tick();

        // 1: single tone, hp = 10
        strobe_note(10'd5, n);
        wait_until(n + 60);
        check("t1_pl_n1",  pl_log[n+1],  0);
        check("t1_pl_n2",  pl_log[n+2],  1);
        check("t1_pl_n46", pl_log[n+46], 1);
        check("t1_pl_n47", pl_log[n+47], 0);
        check("t1_pl_len", count_high(1, n, n + 58), 45);
        for (int k = 1; k <= 50; k++)
            exp_q.push_back((k >= 13 && k <= 22) || (k >= 33 && k <= 42));
        for (int k = 1; k <= 50; k++) begin
            d = k;
            check($sformatf("t1_buzz_n%0d", d), bz_log[n+k], exp_q.pop_front());
        end
        trans = 0;
        for (int k = 2; k <= 50; k++)
            if (bz_log[n+k] !== bz_log[n+k-1]) trans++;
        check("t1_buzz_edges", trans, 4);

        // 2: rest note
        strobe_note(10'd0, n);
        wait_until(n + 60);
        check("t2_buzz_sum", count_high(0, n, n + 58), 0);
        check("t2_pl_len",   count_high(1, n, n + 58), 45);

        // 3: three notes on consecutive cycles while idle
        strobe_note(10'd7, n);
        strobe_note(10'd7, d);
        strobe_note(10'd7, d);
        wait_until(n + 160);
        check("t3_pl_len",  count_high(1, n, n + 155), 135);
        check("t3_pl_n136", pl_log[n+136], 1);
        check("t3_pl_n137", pl_log[n+137], 0);
        check("t3_overflow", ov_log[n+140], 0);

        // 5: end marker during second of two notes, then end marker alone
        strobe_note(10'd2, n);
        strobe_note(10'd4, d);
        wait_until(n + 60);
        pulse_end(d);
        wait_until(n + 110);
        check("t5_pl_n91",   pl_log[n+91], 1);
        check("t5_pl_n92",   pl_log[n+92], 0);
        check("t5_done_n92", dn_log[n+92], 1);
        check("t5_done_cnt", count_high(2, n, n + 105), 1);
        pulse_end(m);
        wait_until(m + 10);
        check("t5_idle_done_m1", dn_log[m+1], 0);
        check("t5_idle_done_m2", dn_log[m+2], 1);
        check("t5_idle_done_cnt", count_high(2, m, m + 8), 1);

        // 4: four strobes while playing with the buffer empty
        strobe_note(10'd3, n);
        wait_until(n + 4);
        for (int k = 0; k < 4; k++) strobe_note(10'd1, d);
        wait_until(n + 160);
        check("t4_rdy_n5",  rdy_log[n+5], 1);
        check("t4_rdy_n6",  rdy_log[n+6], 0);
        check("t4_rdy_n7",  rdy_log[n+7], 0);
        check("t4_ov_n6",   ov_log[n+6],  0);
        check("t4_ov_n7",   ov_log[n+7],  1);
        check("t4_rdy_n50", rdy_log[n+50], 1);
        check("t4_pl_len",  count_high(1, n, n + 155), 135);
        check("t4_pl_n137", pl_log[n+137], 0);
        check("t4_ov_sticky", ov_log[n+150], 1);

        // 6a: mute for a whole note leaves timing unchanged
        mute = 1'b1;
        strobe_note(10'd5, n);
        wait_until(n + 60);
        mute = 1'b0;
        check("t6_mute_buzz", count_high(0, n, n + 58), 0);
        check("t6_mute_len",  count_high(1, n, n + 58), 45);

        // 6b: mute toggle mid-tone, then reset mid-PLAY with one note queued
        strobe_note(10'd5, n);
        strobe_note(10'd6, d);
        wait_until(n + 15);
        mute = 1'b1;
        wait_until(n + 18);
        mute = 1'b0;
        wait_until(n + 25);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wait_until(n + 150);
        check("t6_buzz_n14", bz_log[n+14], 1);
        check("t6_buzz_n15", bz_log[n+15], 0);
        check("t6_buzz_n17", bz_log[n+17], 0);
        check("t6_buzz_n18", bz_log[n+18], 1);
        check("t6_pl_n25",   pl_log[n+25], 1);
        check("t6_pl_n26",   pl_log[n+26], 0);
        check("t6_buzz_n26", bz_log[n+26], 0);
        check("t6_ov_n26",   ov_log[n+26], 0);
        check("t6_rdy_n26",  rdy_log[n+26], 1);
        check("t6_pl_after",   count_high(1, n + 26, n + 145), 0);
        check("t6_buzz_after", count_high(0, n + 26, n + 145), 0);
        check("t6_done_after", count_high(2, n + 26, n + 145), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
